// File: rtl/pipelined_carry_increment_adder.sv
// Two-stage carry-increment adder/subtractor with valid/ready flow control.
// Stage 1 forms per-block sums with carry-in 0; stage 2 ripples block carries as increments.
module pipelined_carry_increment_adder #(
    parameter int N   = 32,
    parameter int BLK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int NB = N / BLK;

    if (N < 2 || BLK < 2 || (N % BLK) != 0) begin : g_bad_param
        $error("pipelined_carry_increment_adder: N must be >= 2 and a multiple of BLK >= 2");
    end

    logic [N-1:0]  b_eff;
    logic          cin_eff;
    logic [N-1:0]  blk_sum;
    logic [NB-1:0] blk_co;
    logic [BLK:0]  blk_t;

    logic          s1_valid;
    logic [N-1:0]  s1_sum;
    logic [NB-1:0] s1_co;
    logic          s1_amsb;
    logic          s1_bmsb;

    logic [N-1:0]  res;
    logic [BLK:0]  inc;
    logic          carry;
    logic          res_ovf;

    logic          s2_can_load;
    logic          in_fire;

    assign b_eff       = sub ? ~b : b;
    assign cin_eff     = sub | cin;
    assign s2_can_load = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_load;
    assign in_fire     = in_valid && in_ready;

    // Block 0 absorbs the effective carry-in, so stage 2 starts its ripple at 0.
    always_comb begin
        blk_sum = '0;
        blk_co  = '0;
        blk_t   = '0;
        for (int j = 0; j < NB; j++) begin
            blk_t = {1'b0, a[j*BLK +: BLK]} + {1'b0, b_eff[j*BLK +: BLK]}
                  + {{BLK{1'b0}}, (j == 0) ? cin_eff : 1'b0};
            blk_sum[j*BLK +: BLK] = blk_t[BLK-1:0];
            blk_co[j]             = blk_t[BLK];
        end
    end

    // A block cannot both generate a carry and overflow on increment, so OR suffices.
    always_comb begin
        res   = '0;
        inc   = '0;
        carry = 1'b0;
        for (int j = 0; j < NB; j++) begin
            inc = {1'b0, s1_sum[j*BLK +: BLK]} + {{BLK{1'b0}}, carry};
            res[j*BLK +: BLK] = inc[BLK-1:0];
            carry = s1_co[j] | inc[BLK];
        end
    end

    assign res_ovf = (s1_amsb == s1_bmsb) && (res[N-1] != s1_amsb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_co     <= '0;
            s1_amsb   <= 1'b0;
            s1_bmsb   <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (s2_can_load) begin
                out_valid <= s1_valid;
            end
            if (s1_valid && s2_can_load) begin
                sum      <= res;
                cout     <= carry;
                overflow <= res_ovf;
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_sum   <= blk_sum;
                s1_co    <= blk_co;
                s1_amsb  <= a[N-1];
                s1_bmsb  <= b_eff[N-1];
            end else if (s2_can_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Scoreboard bench: 32/8 and 16/4 instances share handshakes; results checked against an (N+1)-bit model.
module tb_pipelined_carry_increment_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready, out_valid, cout, overflow;
    logic [31:0] sum;
    logic        in_ready16, out_valid16, cout16, overflow16;
    logic [15:0] sum16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_fires = 0;

    logic [33:0] q32[$];
    logic [17:0] q16[$];
    int          fire_cyc[$];
    logic [33:0] held32;
    logic [17:0] held16;
    bit          hold32 = 0;
    bit          hold16 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_carry_increment_adder #(.N(32), .BLK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    pipelined_carry_increment_adder #(.N(16), .BLK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .overflow(overflow16)
    );

    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic s);
        logic [31:0] yy;
        logic [32:0] r;
        logic        ov;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'b0, (s | ci)};
        ov = (x[31] == yy[31]) && (r[31] != x[31]);
        return {ov, r};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
        logic [15:0] yy;
        logic [16:0] r;
        logic        ov;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, (s | ci)};
        ov = (x[15] == yy[15]) && (r[15] != x[15]);
        return {ov, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: push on accepted input, pop and compare on output transfer, verify stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold32 = 0;
            hold16 = 0;
        end else begin
            if (in_valid && in_ready)   q32.push_back(model32(a, b, cin, sub));
            if (in_valid && in_ready16) q16.push_back(model16(a[15:0], b[15:0], cin, sub));
            check("in_ready_16v32", in_ready16, in_ready);
            if (out_valid) begin
                if (hold32) check("hold32", {overflow, cout, sum}, held32);
                if (out_ready) begin
                    fire_cyc.push_back(cyc);
                    out_fires++;
                    check("q32_nonempty", q32.size() != 0, 1);
                    if (q32.size() != 0) check("result32", {overflow, cout, sum}, q32.pop_front());
                    hold32 = 0;
                end else begin
                    hold32 = 1;
                    held32 = {overflow, cout, sum};
                end
            end else begin
                hold32 = 0;
            end
            if (out_valid16) begin
                if (hold16) check("hold16", {overflow16, cout16, sum16}, held16);
                if (out_ready) begin
                    check("q16_nonempty", q16.size() != 0, 1);
                    if (q16.size() != 0) check("result16", {overflow16, cout16, sum16}, q16.pop_front());
                    hold16 = 0;
                end else begin
                    hold16 = 1;
                    held16 = {overflow16, cout16, sum16};
                end
            end else begin
                hold16 = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        bit ok;
        ok = 0;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_sum"}, sum, es);
            check({tag, "_cout"}, cout, ec);
            check({tag, "_ovf"}, overflow, eo);
        end
        tick();
    endtask

    logic [31:0] st_a[8];
    logic [31:0] st_b[8];
    int          c0, idx, f0;
    bit          saw_nr, drained;

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1);

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        expect_out("carry_blk0", 32'h0000_0100, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        expect_out("carry_all", 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_out("ovf_add", 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        expect_out("ovf_sub", 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        expect_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Back-to-back stream with no backpressure.
        repeat (3) tick();
        fire_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (6) tick();
        check("stream_count", fire_cyc.size(), 8);
        if (fire_cyc.size() == 8) begin
            check("stream_first", fire_cyc[0], c0 + 2);
            for (int i = 1; i < 8; i++) check("stream_consec", fire_cyc[i], fire_cyc[0] + i);
        end

        // Stream with out_ready low for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            st_a[i] = $urandom;
            st_b[i] = $urandom;
        end
        idx = 0; saw_nr = 0; f0 = out_fires;
        for (int i = 0; i < 30; i++) begin
            in_valid  = (idx < 8);
            a         = st_a[idx % 8];
            b         = st_b[idx % 8];
            cin       = 1'(idx % 2);
            sub       = 1'((idx / 2) % 2);
            out_ready = !(i >= 4 && i < 7);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (!in_ready) saw_nr = 1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_saw_not_ready", saw_nr, 1);
        check("bp_all_sent", idx, 8);
        check("bp_all_out", out_fires - f0, 8);

        // Reset with both stages full; in-flight beats must vanish.
        out_ready = 1'b0;
        send(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        q32.delete();
        q16.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_out_valid16", out_valid16, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rel_in_ready", in_ready, 1);
        out_ready = 1'b1;
        f0 = out_fires;
        repeat (6) tick();
        check("rst_no_ghost", out_fires - f0, 0);
        check("rst_no_valid", out_valid, 0);

        // Random traffic on both widths.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = $urandom;
            b         = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 20 && !drained; i++) begin
            tick();
            drained = (q32.size() == 0) && (q16.size() == 0);
        end
        check("drain32", q32.size(), 0);
        check("drain16", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
